program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
Byte-stream program loader that sits directly upstream of the unified instruction/data RAM and drives its load/loadAddress/loadInstruction inputs.
- Accepts a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word with a one-cycle load strobe at consecutive word addresses.
- Holds the CPU stalled for the whole transfer.

Parameters:
START_ADDR, 0, byte address of the first word written (multiple of 4)
MEM_BYTES, 512, usable RAM bytes; maximum word count is MEM_BYTES/4 = 128

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins a load session when in IDLE or ERR, ignored otherwise
rx_valid  input  1  byte available on rx_data
rx_data  input  8  stream byte
rx_ready  output  1  loader can accept a byte this cycle
load  output  1  one-cycle write strobe to RAM load input
loadAddress  output  32  RAM byte address for current word
loadInstruction  output  32  assembled word, first-received byte in [31:24]
cpu_hold  output  1  high whenever state is not IDLE; stalls the pipeline
done  output  1  one-cycle pulse on successful completion
error  output  1  sticky error flag, cleared by start or rst

Behaviour:
- Reset values (asynchronous on rst):
  - State: IDLE.
  - Outputs: rx_ready=0, load=0, loadAddress=START_ADDR, loadInstruction=0, cpu_hold=0, done=0, error=0.
  - Internal word count, byte index and address all cleared.
- A byte transfer occurs on a rising edge with rx_valid=1 and rx_ready=1.
  - rx_ready is a registered function of state only: 1 in HDR_HI, HDR_LO, DATA (and CSUM when enabled), 0 elsewhere.
  - The loader never drops a transferred byte.
  - rx_data is ignored when no transfer occurs.
- Frame format: 2 header bytes giving word count N (16-bit big-endian), followed by 4*N data bytes.
- State machine:
  - IDLE: start -> HDR_HI, clear error, load address register = START_ADDR.
  - HDR_HI: on transfer, capture N[15:8] -> HDR_LO.
  - HDR_LO: on transfer, capture N[7:0], then:
    - N=0 -> DONE.
    - N > MEM_BYTES/4 -> ERR.
    - Otherwise -> DATA with byte index 0.
  - DATA: each transfer shifts the byte into the word register (left shift by 8), byte index +1. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - load=1, loadAddress=current address, loadInstruction=assembled word.
    - Next edge: address += 4, remaining count -= 1, byte index = 0.
    - Then -> DONE if remaining count reaches 0 (or -> CSUM when enabled), else -> DATA.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: error=1, cpu_hold=1, rx_ready=0. Leaves only on start (-> HDR_HI, error cleared) or rst.
- Timing and limits:
  - load is high only in WRITE and never on consecutive cycles. Minimum spacing between strobes is 5 cycles (4 byte transfers + WRITE).
  - loadAddress and loadInstruction are stable throughout the load-high cycle.
  - Address arithmetic is 32-bit unsigned. The count check guarantees the last word address is ≤ START_ADDR + MEM_BYTES - 4, so wrap-around is unreachable.
- Edge cases:
  - start while in any busy state (HDR_*, DATA, WRITE, CSUM, DONE) is ignored.
  - rx_valid held low mid-frame: the loader waits indefinitely. There is no timeout.
  - rst mid-operation: load and cpu_hold drop immediately (asynchronously), the partial word is discarded, and RAM contents already written stay as written.
- cpu_hold timing: rises on the edge leaving IDLE and falls on the edge entering IDLE. It is also high during the DONE cycle.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined:
  - The frame carries one extra trailing byte equal to the XOR of all 4*N data bytes (0x00 when N=0).
  - After the final WRITE, or straight from HDR_LO when N=0, the FSM enters CSUM (rx_ready=1).
  - On transfer: match -> DONE; mismatch -> ERR.
  - Words already written are not rolled back.
- Undefined: the CSUM state and the XOR accumulator are absent, and the frame ends after the last data byte.

Test Plan:
- Reset, then start; stream 00 01 DE AD BE EF with rx_valid always 1 -> exactly one load pulse with loadAddress=0x00000000, loadInstruction=0xDEADBEEF; done pulses once; cpu_hold returns to 0; error=0.
- N=3, words 0x11111111/0x22222222/0x33333333, with rx_valid toggling 1/0 each cycle -> three load pulses at addresses 0, 4, 8 with matching data; no back-to-back load cycles; rx_ready=0 during each WRITE.
- Header 00 81 (N=129) -> ERR: error=1, cpu_hold=1, no load pulse, further bytes not accepted. A new start clears error and restarts at HDR_HI.
- Header 00 00 -> no load pulse, done pulse 3 cycles after start, with no CSUM byte consumed unless the macro is enabled.
- Assert rst after the 2nd data byte of word 1 (N=2) -> load/cpu_hold/rx_ready 0 immediately. A restarted transfer of N=1, 0xCAFEF00D writes address 0 with 0xCAFEF00D, not a merged word.
- With LOADER_CHECKSUM_EN: N=1, 01 02 03 04 plus checksum 04 -> done. The same frame with checksum 05 -> the load at address 0 still occurs, then error=1 and no done pulse.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream in / RAM load bus out for program_loader.
// slave is the loader's view, master the feeder/observer's view.
interface program_loader_if;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        load;
  logic [31:0] loadAddress;
  logic [31:0] loadInstruction;
  logic        cpu_hold;
  logic        done;
  logic        error;

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, load, loadAddress, loadInstruction, cpu_hold, done, error
  );

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, load, loadAddress, loadInstruction, cpu_hold, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream loader: 16-bit BE word count, then 4*N bytes packed into BE 32-bit RAM writes.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module program_loader #(
  parameter logic [31:0] START_ADDR = 32'h0,
  parameter int unsigned MEM_BYTES  = 512
) (
  input logic             clk,
  input logic             rst,
  program_loader_if.slave bus
);

  localparam int unsigned MaxWords = MEM_BYTES / 4;

  typedef enum logic [2:0] {
    StIdle,
    StHdrHi,
    StHdrLo,
    StData,
    StWrite,
`ifdef LOADER_CHECKSUM_EN
    StCsum,
`endif
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] word_q, word_d;
  logic [15:0] hdr_n;
  logic        xfer;
  logic        ready_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  assign xfer  = bus.rx_valid & bus.rx_ready;
  assign hdr_n = {count_q[15:8], bus.rx_data};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    word_d  = word_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      StIdle, StErr: begin
        if (bus.start) begin
          state_d = StHdrHi;
          addr_d  = START_ADDR;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      StHdrHi: begin
        if (xfer) begin
          count_d = {bus.rx_data, 8'h00};
          state_d = StHdrLo;
        end
      end
      StHdrLo: begin
        if (xfer) begin
          count_d = hdr_n;
          idx_d   = 2'd0;
          if (hdr_n == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else if (32'(hdr_n) > MaxWords) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          word_d = {word_q[23:0], bus.rx_data};
          idx_d  = idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_d = csum_q ^ bus.rx_data;
`endif
          if (idx_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        // Address/count advance on the edge that ends the load strobe.
        addr_d  = addr_q + 32'd4;
        count_d = count_q - 16'd1;
        idx_d   = 2'd0;
        if (count_q == 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StData;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      StCsum: begin
        if (xfer) state_d = (bus.rx_data == csum_q) ? StDone : StErr;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    unique case (state_d)
      StHdrHi, StHdrLo, StData: ready_d = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      StCsum:                   ready_d = 1'b1;
`endif
      default:                  ready_d = 1'b0;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      count_q      <= 16'd0;
      idx_q        <= 2'd0;
      addr_q       <= START_ADDR;
      word_q       <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
      bus.rx_ready <= 1'b0;
      bus.load     <= 1'b0;
      bus.cpu_hold <= 1'b0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      addr_q       <= addr_d;
      word_q       <= word_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
      bus.rx_ready <= ready_d;
      bus.load     <= (state_d == StWrite);
      bus.cpu_hold <= (state_d != StIdle);
      bus.done     <= (state_d == StDone);
      bus.error    <= (state_d == StErr);
    end
  end

  assign bus.loadAddress     = addr_q;
  assign bus.loadInstruction = word_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized frames checked
// against a word-list model of expected RAM writes.
module tb_program_loader;
  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  localparam logic [31:0] StartAddr = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;

  program_loader_if bus ();

  program_loader #(
    .START_ADDR(StartAddr),
    .MEM_BYTES (512)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int   b2b          = 0;
  int   rdy_in_write = 0;
  int   done_cnt     = 0;
  logic prev_load    = 1'b0;

  // Observer of the RAM side, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.load) begin
      log_addr.push_back(bus.loadAddress);
      log_data.push_back(bus.loadInstruction);
      if (prev_load) b2b <= b2b + 1;
      if (bus.rx_ready) rdy_in_write <= rdy_in_write + 1;
    end
    if (bus.done) done_cnt <= done_cnt + 1;
    prev_load <= bus.load;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic byte_q_t make_frame(input word_q_t w);
    byte_q_t     b;
    logic [15:0] n;
    n = 16'(w.size());
    b.push_back(n[15:8]);
    b.push_back(n[7:0]);
    foreach (w[k]) begin
      for (int j = 3; j >= 0; j--) b.push_back(w[k][j*8 +: 8]);
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 2; i < b.size(); i++) x = x ^ b[i];
      b.push_back(x);
    end
`endif
    return b;
  endfunction

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // mode 0: valid always, 1: valid toggles, other: random valid
  task automatic drive_bytes(input byte_q_t b, input int mode);
    int i;
    int cyc;
    i   = 0;
    cyc = 0;
    while (i < b.size() && cyc < 4000) begin
      @(negedge clk);
      case (mode)
        0:       bus.rx_valid = 1'b1;
        1:       bus.rx_valid = (cyc % 2 == 0);
        default: bus.rx_valid = 1'($urandom_range(0, 1));
      endcase
      bus.rx_data = bus.rx_valid ? b[i] : 8'($urandom);
      if (bus.rx_valid && bus.rx_ready) i++;
      cyc++;
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
    chk("bytes_taken", i, b.size());
  endtask

  task automatic wait_end(input int base_done);
    int c;
    c = 0;
    while (done_cnt == base_done && !bus.error && c < 2000) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("end_reached", 32'(c < 2000), 1);
  endtask

  task automatic run_frame(input word_q_t w, input int mode);
    int lb;
    int db;
    lb = log_addr.size();
    db = done_cnt;
    start_pulse();
    drive_bytes(make_frame(w), mode);
    wait_end(db);
    chk("nloads", log_addr.size() - lb, w.size());
    foreach (w[k]) begin
      if (lb + k < log_addr.size()) begin
        chk("load_addr", log_addr[lb+k], StartAddr + 32'(4 * k));
        chk("load_data", log_data[lb+k], w[k]);
      end
    end
    chk("done_once", done_cnt - db, 1);
    chk("no_error", bus.error, 0);
    @(negedge clk);
    #1;
    chk("hold_released", bus.cpu_hold, 0);
    chk("done_cleared", bus.done, 0);
  endtask

  word_q_t rw;
  byte_q_t fr;
  int      lb0;
  int      db0;
  int      b2b0;
  int      rw0;
  int      acc;
  int      nw;

  initial begin
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    #2 rst = 1'b1;
    #1;
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_load", bus.load, 0);
    chk("rst_addr", bus.loadAddress, StartAddr);
    chk("rst_instr", bus.loadInstruction, 0);
    chk("rst_hold", bus.cpu_hold, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single word, continuous valid.
    run_frame('{32'hDEADBEEF}, 0);

    // Three words with valid toggling; strobes must not be adjacent nor overlap rx_ready.
    b2b0 = b2b;
    rw0  = rdy_in_write;
    run_frame('{32'h11111111, 32'h22222222, 32'h33333333}, 1);
    chk("no_b2b_load", b2b - b2b0, 0);
    chk("ready_low_in_write", rdy_in_write - rw0, 0);

    // Over-limit count goes to error and refuses bytes.
    lb0 = log_addr.size();
    db0 = done_cnt;
    start_pulse();
    drive_bytes('{8'h00, 8'h81}, 0);
    wait_end(db0);
    chk("err_flag", bus.error, 1);
    chk("err_hold", bus.cpu_hold, 1);
    chk("err_no_load", log_addr.size() - lb0, 0);
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = 8'($urandom);
      if (bus.rx_ready) acc++;
    end
    bus.rx_valid = 1'b0;
    chk("err_no_accept", acc, 0);
    chk("err_sticky", bus.error, 1);
    start_pulse();
    #1;
    chk("restart_err_clr", bus.error, 0);
    chk("restart_hdr_ready", bus.rx_ready, 1);
    // Already in HDR_HI, so run_frame's own start pulse must be ignored.
    run_frame('{32'h0BADC0DE}, 0);

    // Zero-length frame: done three cycles after start (four with a checksum byte).
    lb0 = log_addr.size();
    db0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h00;
    @(negedge clk);
    bus.rx_data  = 8'h00;
`ifdef LOADER_CHECKSUM_EN
    @(negedge clk);
    bus.rx_data  = 8'h00;
`endif
    @(negedge clk);
    bus.rx_valid = 1'b0;
    #1;
    chk("n0_done", bus.done, 1);
    chk("n0_ready_low", bus.rx_ready, 0);
    chk("n0_no_load", log_addr.size() - lb0, 0);
    @(negedge clk);
    #1;
    chk("n0_hold_low", bus.cpu_hold, 0);
    chk("n0_done_once", done_cnt - db0, 1);

    // Reset mid-word, then a fresh frame must not merge old bytes.
    start_pulse();
    drive_bytes('{8'h00, 8'h02, 8'hAA, 8'hBB}, 0);
    #1;
    chk("pre_rst_hold", bus.cpu_hold, 1);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_load", bus.load, 0);
    chk("mid_rst_hold", bus.cpu_hold, 0);
    chk("mid_rst_ready", bus.rx_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    run_frame('{32'hCAFEF00D}, 0);

    // Largest legal frame: last write lands at START_ADDR + MEM_BYTES - 4.
    rw.delete();
    for (int k = 0; k < 128; k++) rw.push_back($urandom);
    run_frame(rw, 0);

    // Randomized frames with random valid gaps.
    for (int r = 0; r < 4; r++) begin
      rw.delete();
      nw = $urandom_range(1, 6);
      for (int k = 0; k < nw; k++) rw.push_back($urandom);
      run_frame(rw, 2);
    end

    // Random over-limit header.
    nw = $urandom_range(129, 65535);
    lb0 = log_addr.size();
    db0 = done_cnt;
    start_pulse();
    drive_bytes('{8'(nw >> 8), 8'(nw)}, 2);
    wait_end(db0);
    chk("rand_err_flag", bus.error, 1);
    chk("rand_err_no_load", log_addr.size() - lb0, 0);
    run_frame('{32'h12345678, 32'h9ABCDEF0}, 2);

`ifdef LOADER_CHECKSUM_EN
    run_frame('{32'h01020304}, 0);
    lb0 = log_addr.size();
    db0 = done_cnt;
    start_pulse();
    fr = make_frame('{32'h01020304});
    fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
    drive_bytes(fr, 0);
    wait_end(db0);
    chk("bad_csum_load", log_addr.size() - lb0, 1);
    if (log_addr.size() > lb0) begin
      chk("bad_csum_addr", log_addr[lb0], StartAddr);
      chk("bad_csum_data", log_data[lb0], 32'h01020304);
    end
    chk("bad_csum_err", bus.error, 1);
    chk("bad_csum_no_done", done_cnt - db0, 0);
    run_frame('{32'hA5A55A5A}, 2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
